// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the SRAM arbiter/sequencer: FSM state encodings,
// requester port indices and a helper used to size the wait counter.
// Optional feature macro: SRAM_CTRL_RR_EN (round-robin arbitration).
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    SC_IDLE  = 3'd0,
    SC_RD    = 3'd1,
    SC_WR_SU = 3'd2,
    SC_WR_PL = 3'd3,
    SC_WR_HD = 3'd4
  } state_e;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  function automatic int max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/sram_ctrl_arb.sv
// Combinational grant logic for the two SRAM requesters. A port acked in the
// current cycle is masked so its stale request is not re-granted.
// With SRAM_CTRL_RR_EN defined, ties go to the port that was not granted last;
// otherwise port 0 always wins a tie.
module sram_ctrl_arb
  import sram_ctrl_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic mask0,
  input  logic mask1,
`ifdef SRAM_CTRL_RR_EN
  input  logic last_grant,
`endif
  output logic gnt_valid,
  output logic gnt_port
);

  logic elig0;
  logic elig1;

  // Pick a winner among the unmasked requesters
  always_comb begin
    elig0     = req0 & ~mask0;
    elig1     = req1 & ~mask1;
    gnt_valid = elig0 | elig1;
    gnt_port  = PORT0;
    if (elig0 && elig1) begin
`ifdef SRAM_CTRL_RR_EN
      gnt_port = (last_grant == PORT0) ? PORT1 : PORT0;
`else
      gnt_port = PORT0;
`endif
    end else if (elig1) begin
      gnt_port = PORT1;
    end
  end

endmodule

// File: rtl/sram_ctrl.sv
// Two-port arbiter and access sequencer for an asynchronous SRAM.
// Holds the access FSM, the shared wait-state down-counter, the latched
// request and the registered pin drivers. Strobes and the data-drive enable
// come straight from flops so the SRAM pins never glitch.
// Optional feature macro: SRAM_CTRL_RR_EN (round-robin arbitration).
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int RD_WAIT    = 3,
  parameter int WR_SETUP   = 1,
  parameter int WR_PULSE   = 2,
  parameter int WR_HOLD    = 1
) (
  input  logic                  clk,
  input  logic                  notReset,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  sram_notCS,
  output logic                  sram_notOE,
  output logic                  sram_notWE
);

  localparam int MAX_WAIT = max4(RD_WAIT, WR_SETUP, WR_PULSE, WR_HOLD);
  localparam int CNT_W    = $clog2(MAX_WAIT) + 1;
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_WAIT - 1);
  localparam logic [CNT_W-1:0] SU_LOAD = CNT_W'(WR_SETUP - 1);
  localparam logic [CNT_W-1:0] PL_LOAD = CNT_W'(WR_PULSE - 1);
  localparam logic [CNT_W-1:0] HD_LOAD = CNT_W'(WR_HOLD - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  port_q, port_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  ack0_q, ack0_d;
  logic                  ack1_q, ack1_d;
  logic                  notcs_q, notcs_d;
  logic                  notoe_q, notoe_d;
  logic                  notwe_q, notwe_d;
  logic                  drive_q, drive_d;
  logic                  gnt_valid;
  logic                  gnt_port;
  logic                  gnt_we;
`ifdef SRAM_CTRL_RR_EN
  logic                  last_grant_q, last_grant_d;
`endif

  sram_ctrl_arb u_arb (
    .req0       (req0),
    .req1       (req1),
    .mask0      (ack0_q),
    .mask1      (ack1_q),
`ifdef SRAM_CTRL_RR_EN
    .last_grant (last_grant_q),
`endif
    .gnt_valid  (gnt_valid),
    .gnt_port   (gnt_port)
  );

  assign gnt_we = (gnt_port == PORT1) ? we1 : we0;

  // Next-state, counter and pin values; arbitration is only honoured in IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    port_d  = port_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    notcs_d = notcs_q;
    notoe_d = notoe_q;
    notwe_d = notwe_q;
    drive_d = drive_q;
`ifdef SRAM_CTRL_RR_EN
    last_grant_d = last_grant_q;
`endif
    case (state_q)
      SC_IDLE: begin
        if (gnt_valid) begin
          port_d  = gnt_port;
          addr_d  = (gnt_port == PORT1) ? addr1 : addr0;
          wdata_d = (gnt_port == PORT1) ? wdata1 : wdata0;
          notcs_d = 1'b0;
`ifdef SRAM_CTRL_RR_EN
          last_grant_d = gnt_port;
`endif
          if (gnt_we) begin
            state_d = SC_WR_SU;
            cnt_d   = SU_LOAD;
            drive_d = 1'b1;
          end else begin
            state_d = SC_RD;
            cnt_d   = RD_LOAD;
            notoe_d = 1'b0;
          end
        end
      end
      SC_RD: begin
        if (cnt_q == '0) begin
          state_d = SC_IDLE;
          rdata_d = sram_data;
          ack0_d  = (port_q == PORT0);
          ack1_d  = (port_q == PORT1);
          notcs_d = 1'b1;
          notoe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SC_WR_SU: begin
        if (cnt_q == '0) begin
          state_d = SC_WR_PL;
          cnt_d   = PL_LOAD;
          notwe_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SC_WR_PL: begin
        if (cnt_q == '0) begin
          state_d = SC_WR_HD;
          cnt_d   = HD_LOAD;
          notwe_d = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      SC_WR_HD: begin
        if (cnt_q == '0) begin
          state_d = SC_IDLE;
          ack0_d  = (port_q == PORT0);
          ack1_d  = (port_q == PORT1);
          notcs_d = 1'b1;
          drive_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = SC_IDLE;
        notcs_d = 1'b1;
        notoe_d = 1'b1;
        notwe_d = 1'b1;
        drive_d = 1'b0;
      end
    endcase
  end

  // State and pin registers; reset releases the bus immediately
  always_ff @(posedge clk or negedge notReset) begin
    if (!notReset) begin
      state_q <= SC_IDLE;
      cnt_q   <= '0;
      port_q  <= PORT0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      notcs_q <= 1'b1;
      notoe_q <= 1'b1;
      notwe_q <= 1'b1;
      drive_q <= 1'b0;
`ifdef SRAM_CTRL_RR_EN
      last_grant_q <= PORT1;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      port_q  <= port_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack0_q  <= ack0_d;
      ack1_q  <= ack1_d;
      notcs_q <= notcs_d;
      notoe_q <= notoe_d;
      notwe_q <= notwe_d;
      drive_q <= drive_d;
`ifdef SRAM_CTRL_RR_EN
      last_grant_q <= last_grant_d;
`endif
    end
  end

  assign ack0       = ack0_q;
  assign ack1       = ack1_q;
  assign rdata      = rdata_q;
  assign sram_addr  = addr_q;
  assign sram_notCS = notcs_q;
  assign sram_notOE = notoe_q;
  assign sram_notWE = notwe_q;
  assign sram_data  = drive_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Testbench for sram_ctrl with a behavioural asynchronous SRAM on the pins.
// Expected completions are queued when requests are issued and checked
// in order as acks appear. Honours SRAM_CTRL_RR_EN for arbitration order.
module tb_sram_ctrl;

  localparam int RD_WAIT  = 3;
  localparam int WR_SETUP = 1;
  localparam int WR_PULSE = 2;
  localparam int WR_HOLD  = 1;
  localparam int RD_LAT   = RD_WAIT + 1;
  localparam int WR_LAT   = WR_SETUP + WR_PULSE + WR_HOLD + 1;
  localparam int MAX_WAIT = 100;

  logic        clk = 1'b0;
  logic        notReset = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0;
  logic [15:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
  logic        ack0, ack1;
  logic [15:0] rdata, sram_addr;
  wire  [15:0] sram_data;
  logic        sram_notCS, sram_notOE, sram_notWE;

  sram_ctrl #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (16),
    .RD_WAIT    (RD_WAIT),
    .WR_SETUP   (WR_SETUP),
    .WR_PULSE   (WR_PULSE),
    .WR_HOLD    (WR_HOLD)
  ) dut (
    .clk        (clk),
    .notReset   (notReset),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata      (rdata),
    .sram_addr  (sram_addr),
    .sram_data  (sram_data),
    .sram_notCS (sram_notCS),
    .sram_notOE (sram_notOE),
    .sram_notWE (sram_notWE)
  );

  // 20 ns clock
  always #10 clk = ~clk;

  // Behavioural SRAM: drives data during reads, captures it while notWE is low
  logic [15:0] mem [0:65535];
  wire sramDrive = !sram_notCS && !sram_notOE && sram_notWE;
  assign sram_data = sramDrive ? mem[sram_addr] : 16'hzzzz;
  always @(posedge clk) begin
    if (!sram_notCS && !sram_notWE) mem[sram_addr] <= sram_data;
  end

  typedef struct {
    bit          port;
    bit          isRead;
    logic [15:0] data;
  } exp_t;

  typedef struct {
    bit          port;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
  } vec_t;

  exp_t        expQ[$];
  logic [15:0] shadow [logic [15:0]];
  vec_t        vecs [7];
  logic [15:0] t6Addr [0:7];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          weLowRun = 0;
  int          lastWeLow = 0;
  bit          overlapSeen = 1'b0;

  // Free-running cycle count used for ack spacing
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] expRead(input logic [15:0] a);
    return shadow.exists(a) ? shadow[a] : 16'h0000;
  endfunction

  function automatic logic ackOf(input bit p);
    return p ? ack1 : ack0;
  endfunction

  // Scoreboard pop for one ack
  task automatic scoreCheck(input bit p);
    exp_t e;
    if (expQ.size() == 0) begin
      checkOutput("ack with empty scoreboard", 32'(p) + 1, 0);
    end else begin
      e = expQ.pop_front();
      checkOutput("ack port order", 32'(p), 32'(e.port));
      if (e.isRead) checkOutput("rdata", 32'(rdata), 32'(e.data));
    end
  endtask

  // Pin monitor: strobe overlap, notWE pulse width, ack scoreboard
  always @(negedge clk) begin
    if (notReset) begin
      if (!sram_notOE && !sram_notWE) overlapSeen = 1'b1;
      if (!sram_notWE) weLowRun++;
      else if (weLowRun != 0) begin
        lastWeLow = weLowRun;
        weLowRun = 0;
      end
      if (ack0 && ack1) checkOutput("both acks together", 2, 1);
      if (ack0) scoreCheck(1'b0);
      if (ack1) scoreCheck(1'b1);
    end else begin
      weLowRun = 0;
    end
  end

  task automatic driveReq(input bit p, input bit r, input bit we, input logic [15:0] a, input logic [15:0] d);
    if (p) begin req1 = r; we1 = we; addr1 = a; wdata1 = d; end
    else   begin req0 = r; we0 = we; addr0 = a; wdata0 = d; end
  endtask

  // Raise a request and queue its expected completion
  task automatic issue(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d);
    exp_t e;
    e.port   = p;
    e.isRead = !we;
    e.data   = we ? d : expRead(a);
    if (we) shadow[a] = d;
    expQ.push_back(e);
    driveReq(p, 1'b1, we, a, d);
  endtask

  task automatic dropReq(input bit p);
    if (p) req1 = 1'b0; else req0 = 1'b0;
  endtask

  task automatic waitAny(output bit p, output int t, output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(ack0 || ack1) && n < MAX_WAIT);
    ok = ack0 || ack1;
    if (!ok) checkOutput("ack timeout", 0, 1);
    p = ack1;
    t = cyc;
  endtask

  // Single isolated access; returns the request-to-ack latency in cycles
  task automatic applyStimulus(input bit p, input bit we, input logic [15:0] a, input logic [15:0] d, output int lat);
    issue(p, we, a, d);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!ackOf(p) && lat < MAX_WAIT);
    dropReq(p);
  endtask

  initial begin
    int  lat, t, tPrev, ackCount, k, acks;
    bit  p, p1, ok;
    int  t1;

    vecs[0] = '{port: 1'b0, we: 1'b1, addr: 16'h0010, wdata: 16'hBEEF, lat: WR_LAT};
    vecs[1] = '{port: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, lat: RD_LAT};
    vecs[2] = '{port: 1'b1, we: 1'b1, addr: 16'h0100, wdata: 16'hCAFE, lat: WR_LAT};
    vecs[3] = '{port: 1'b1, we: 1'b0, addr: 16'h0100, wdata: 16'h0000, lat: RD_LAT};
    vecs[4] = '{port: 1'b0, we: 1'b1, addr: 16'hFFFF, wdata: 16'h8001, lat: WR_LAT};
    vecs[5] = '{port: 1'b1, we: 1'b0, addr: 16'hFFFF, wdata: 16'h0000, lat: RD_LAT};
    vecs[6] = '{port: 1'b0, we: 1'b0, addr: 16'h0010, wdata: 16'h0000, lat: RD_LAT};
    t6Addr = '{16'h0000, 16'h0001, 16'h0002, 16'h0003, 16'h0010, 16'h0100, 16'hFFFF, 16'h0000};

    // Reset state
    #5 notReset = 1'b0;
    #1;
    checkOutput("reset notCS", 32'(sram_notCS), 1);
    checkOutput("reset notOE", 32'(sram_notOE), 1);
    checkOutput("reset notWE", 32'(sram_notWE), 1);
    checkOutput("reset acks", {ack0, ack1}, 0);
    checkOutput("reset rdata", 32'(rdata), 0);
    checkOutput("reset sram_addr", 32'(sram_addr), 0);
    checkOutput("reset bus Z", 32'(sram_data === 16'hzzzz), 1);
    repeat (3) @(negedge clk);
    notReset = 1'b1;
    @(negedge clk);

    // Isolated accesses from the vector table
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat);
      checkOutput($sformatf("vec%0d latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("vec%0d bus Z at ack", i), 32'(sram_data === 16'hzzzz), 1);
      if (vecs[i].we) checkOutput($sformatf("vec%0d notWE width", i), lastWeLow, WR_PULSE);
      @(negedge clk);
    end

    // Simultaneous reads; port 0 was granted last
    applyStimulus(1'b0, 1'b1, 16'h0001, 16'h0A01, lat);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 16'h0002, 16'h0A02, lat);
    @(negedge clk);
`ifdef SRAM_CTRL_RR_EN
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    issue(1'b0, 1'b0, 16'h0001, 16'h0000);
    p1 = 1'b1;
`else
    issue(1'b0, 1'b0, 16'h0001, 16'h0000);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    p1 = 1'b0;
`endif
    waitAny(p, t1, ok);
    checkOutput("tie first winner", 32'(p), 32'(p1));
    dropReq(p);
    waitAny(p, t, ok);
    checkOutput("tie second port", 32'(p), 32'(!p1));
    checkOutput("cross-port ack spacing", t - t1, RD_LAT);
    dropReq(p);
    @(negedge clk);

    // Back-to-back port 1 writes; the masked ack cycle plus the grant cycle separate them
    issue(1'b1, 1'b1, 16'h0000, 16'h1111);
    for (int i = 0; i < 4; i++) begin
      waitAny(p, t, ok);
      checkOutput("b2b write port", 32'(p), 1);
      if (i > 0) checkOutput("b2b write spacing", t - tPrev, WR_LAT + 1);
      tPrev = t;
      if (i < 3) issue(1'b1, 1'b1, 16'(i + 1), 16'h1111 * 16'(i + 2));
      else dropReq(1'b1);
    end
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h0000, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      waitAny(p, t, ok);
      if (i > 0) checkOutput("b2b read spacing", t - tPrev, RD_LAT + 1);
      tPrev = t;
      if (i < 3) issue(1'b1, 1'b0, 16'(i + 1), 16'h0000);
      else dropReq(1'b1);
    end
    @(negedge clk);

    // Reset in the middle of the write pulse
    applyStimulus(1'b0, 1'b1, 16'h0021, 16'hA5A5, lat);
    @(negedge clk);
    driveReq(1'b0, 1'b1, 1'b1, 16'h0020, 16'h5555);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (sram_notWE && k < MAX_WAIT);
    checkOutput("reached write pulse", 32'(sram_notWE), 0);
    notReset = 1'b0;
    #1;
    checkOutput("abort strobes high", {sram_notCS, sram_notOE, sram_notWE}, 3'b111);
    checkOutput("abort bus Z", 32'(sram_data === 16'hzzzz), 1);
    checkOutput("abort rdata cleared", 32'(rdata), 0);
    dropReq(1'b0);
    repeat (2) @(negedge clk);
    notReset = 1'b1;
    ackCount = 0;
    repeat (8) begin
      @(negedge clk);
      if (ack0 || ack1) ackCount++;
    end
    checkOutput("no ack after abort", ackCount, 0);
    applyStimulus(1'b0, 1'b0, 16'h0021, 16'h0000, lat);
    checkOutput("read after abort latency", lat, RD_LAT);
    @(negedge clk);

    // Port 0 drops its request after the grant; port 1 follows
    issue(1'b0, 1'b0, 16'h0010, 16'h0000);
    @(negedge clk);
    dropReq(1'b0);
    issue(1'b1, 1'b0, 16'h0100, 16'h0000);
    waitAny(p, t1, ok);
    checkOutput("dropped req still acked", 32'(p), 0);
    waitAny(p, t, ok);
    checkOutput("port1 after drop", 32'(p), 1);
    checkOutput("port1 after drop spacing", t - t1, RD_LAT);
    dropReq(1'b1);
    ackCount = 0;
    repeat (6) begin
      @(negedge clk);
      if (ack0 || ack1) ackCount++;
    end
    checkOutput("single ack0 pulse", ackCount, 0);

    // Port 0 streams 8 reads while port 1 waits; the masked ack0 cycle lets port 1 in
    issue(1'b0, 1'b0, t6Addr[0], 16'h0000);
    issue(1'b1, 1'b0, 16'h0002, 16'h0000);
    k = 1;
    acks = 0;
    ok = 1'b1;
    while (acks < 9 && ok) begin
      waitAny(p, t, ok);
      if (ok) begin
        acks++;
        if (acks == 1) checkOutput("stream first ack", 32'(p), 0);
        if (acks == 2) checkOutput("stream port1 served", 32'(p), 1);
        if (p == 1'b0) begin
          if (k < 8) begin
            issue(1'b0, 1'b0, t6Addr[k], 16'h0000);
            k++;
          end else begin
            dropReq(1'b0);
          end
        end else begin
          dropReq(1'b1);
        end
      end
    end
    checkOutput("stream ack count", acks, 9);
    repeat (4) @(negedge clk);

    checkOutput("scoreboard drained", expQ.size(), 0);
    checkOutput("notOE/notWE overlap", 32'(overlapSeen), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
